// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch queue in front of a one-cycle-latency
// instruction memory. It issues sequential 16-bit fetches and buffers the
// responses in a small ring buffer. The consumer sees them through a
// valid/ready handshake. A redirect restarts fetching at a new address, and a
// fetched 16'hFFFF halt word stops all further fetching.
module fetch_queue #(
  parameter int DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [15:0] instr,
  output logic [15:0] instr_pc,
  output logic        halted
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int OCC_W = CNT_W + 1;
  localparam logic [OCC_W-1:0] DEPTH_L = OCC_W'(DEPTH);

  logic [15:0]      fetch_pc_r;
  logic             inflight_r;
  logic [15:0]      inflight_pc_r;
  logic             stop_r;
  logic             halted_r;
  logic [CNT_W-1:0] count_r;
  logic [PTR_W-1:0] head_r;
  logic [PTR_W-1:0] tail_r;
  logic [15:0]      word_mem_r [DEPTH];
  logic [15:0]      pc_mem_r   [DEPTH];

  logic             pop_s;
  logic             push_s;
  logic             halt_pop_s;
  logic [OCC_W-1:0] occupancy_s;

  assign imem_addr = fetch_pc_r;

  // Head presentation; everything the consumer sees is forced low during reset.
  always_comb begin
    instr_valid = ~reset & (count_r != {CNT_W{1'b0}});
    instr       = instr_valid ? word_mem_r[head_r] : 16'h0000;
    instr_pc    = instr_valid ? pc_mem_r[head_r]   : 16'h0000;
    halted      = halted_r & ~reset;
  end

  // Handshake decode and request issue: a new request is only made when
  // the queue will still have room for its response after this cycle's pop.
  always_comb begin
    pop_s       = instr_valid & instr_ready;
    push_s      = inflight_r & ~stop_r & ~redirect & ~reset;
    halt_pop_s  = pop_s & (instr == 16'hFFFF);
    occupancy_s = {1'b0, count_r}
                + {{CNT_W{1'b0}}, inflight_r}
                - {{CNT_W{1'b0}}, pop_s};
    imem_req    = ~reset & ~redirect & ~stop_r & (occupancy_s < DEPTH_L);
  end

  // Queue storage and the address of the outstanding request; no reset needed
  // because occupancy and the inflight flag qualify every use of these.
  always_ff @(posedge clock) begin
    if (push_s) begin
      word_mem_r[tail_r] <= imem_rdata;
      pc_mem_r[tail_r]   <= inflight_pc_r;
    end
    if (imem_req) begin
      inflight_pc_r <= fetch_pc_r;
    end
  end

  // Control state: reset, then redirect, then normal fetch/push/pop/halt.
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc_r <= 16'h0000;
      inflight_r <= 1'b0;
      stop_r     <= 1'b0;
      halted_r   <= 1'b0;
      count_r    <= {CNT_W{1'b0}};
      head_r     <= {PTR_W{1'b0}};
      tail_r     <= {PTR_W{1'b0}};
    end else if (redirect) begin
      fetch_pc_r <= {redirect_pc[15:1], 1'b0};
      inflight_r <= 1'b0;
      stop_r     <= 1'b0;
      halted_r   <= 1'b0;
      count_r    <= {CNT_W{1'b0}};
      head_r     <= {PTR_W{1'b0}};
      tail_r     <= {PTR_W{1'b0}};
    end else begin
      if (imem_req) begin
        fetch_pc_r <= fetch_pc_r + 16'h0002;
      end
      inflight_r <= imem_req;
      if (push_s) begin
        tail_r <= tail_r + PTR_W'(1);
        if (imem_rdata == 16'hFFFF) begin
          stop_r <= 1'b1;
        end
      end
      if (pop_s) begin
        head_r <= head_r + PTR_W'(1);
      end
      if (halt_pop_s) begin
        halted_r <= 1'b1;
      end
      count_r <= count_r + CNT_W'(push_s) - CNT_W'(pop_s);
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed scenarios followed by randomized traffic. A
// queue-based reference model predicts every output in every cycle.
module tb_fetch_queue;

  localparam int DEPTH = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        halted;

  always #5 clock = ~clock;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clock       (clock),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .halted      (halted)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the queue of instructions waiting to be delivered,
  // the next fetch address, the outstanding request and the halt flags.
  typedef struct packed {
    logic [15:0] word;
    logic [15:0] pc;
  } entry_t;

  entry_t      mq[$];
  logic [15:0] m_fpc = 16'h0000;
  bit          m_infl = 1'b0;
  logic [15:0] m_infl_pc = 16'h0000;
  bit          m_stop = 1'b0;
  bit          m_halted = 1'b0;
  bit          m_known = 1'b0;

  // Memory image configuration.
  bit          halt_en = 1'b0;
  logic [15:0] halt_addr = 16'h0000;
  bit          scramble = 1'b0;

  // What the DUT requested in the previous cycle (drives the memory response).
  bit          last_req = 1'b0;
  logic [15:0] last_addr = 16'h0000;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (halt_en && a == halt_addr) return 16'hFFFF;
    return scramble ? (a ^ 16'h5A00) : a;
  endfunction

  // One clock cycle: drive inputs, predict and compare outputs, advance model.
  task automatic cycle(input bit rst, input bit rdr, input logic [15:0] rpc, input bit rdy);
    bit          e_req;
    bit          e_valid;
    bit          pop;
    logic [15:0] e_instr;
    logic [15:0] e_pc;
    int          occ;
    entry_t      e;
    reset       = rst;
    redirect    = rdr;
    redirect_pc = rpc;
    instr_ready = rdy;
    imem_rdata  = last_req ? mem_word(last_addr) : 16'($urandom);
    #1;
    e_valid = !rst && (mq.size() != 0);
    e_instr = e_valid ? mq[0].word : 16'h0000;
    e_pc    = e_valid ? mq[0].pc   : 16'h0000;
    pop     = e_valid && rdy;
    occ     = mq.size() + int'(m_infl) - int'(pop);
    e_req   = !rst && !rdr && !m_stop && (occ < DEPTH);
    check("imem_req",    32'(imem_req),    32'(e_req));
    if (m_known) check("imem_addr", 32'(imem_addr), 32'(m_fpc));
    check("instr_valid", 32'(instr_valid), 32'(e_valid));
    check("instr",       32'(instr),       32'(e_instr));
    check("instr_pc",    32'(instr_pc),    32'(e_pc));
    check("halted",      32'(halted),      32'(!rst && m_halted));
    last_req  = imem_req;
    last_addr = imem_addr;
    if (rst) begin
      mq.delete();
      m_fpc = 16'h0000; m_infl = 1'b0; m_stop = 1'b0; m_halted = 1'b0;
      m_known = 1'b1;
    end else if (rdr) begin
      mq.delete();
      m_fpc = rpc & 16'hFFFE; m_infl = 1'b0; m_stop = 1'b0; m_halted = 1'b0;
    end else begin
      if (pop) begin
        if (mq[0].word == 16'hFFFF) m_halted = 1'b1;
        void'(mq.pop_front());
      end
      if (m_infl && !m_stop) begin
        e.word = mem_word(m_infl_pc);
        e.pc   = m_infl_pc;
        mq.push_back(e);
        if (e.word == 16'hFFFF) m_stop = 1'b1;
      end
      m_infl    = e_req;
      m_infl_pc = m_fpc;
      if (e_req) m_fpc = m_fpc + 16'h0002;
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    bit          stalled;
    bit          rst;
    bit          rdr;
    bit          rdy;
    logic [15:0] rpc;
    reset = 1'b1; redirect = 1'b0; redirect_pc = 16'h0000;
    instr_ready = 1'b0; imem_rdata = 16'h0000;
    @(posedge clock);
    #1;

    // Reset, then streaming with memory word = address.
    cycle(1'b1, 1'b0, 16'h0000, 1'b1);
    cycle(1'b1, 1'b0, 16'h0000, 1'b1);
    for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0, 16'h0000, 1'b1);

    // Backpressure, then release.
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 16'h0000, 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 16'h0000, 1'b1);

    // Fill the queue, then redirect to an odd address.
    stalled = 1'b0;
    for (int n = 0; n < 20 && !stalled; n++) begin
      cycle(1'b0, 1'b0, 16'h0000, 1'b0);
      stalled = !last_req;
    end
    check("fill_stall", 32'(last_req), 32'd0);
    cycle(1'b0, 1'b0, 16'h0000, 1'b0);
    cycle(1'b0, 1'b1, 16'h0041, 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 16'h0000, 1'b1);

    // Halt word at address 8.
    halt_en = 1'b1; halt_addr = 16'h0008;
    cycle(1'b1, 1'b0, 16'h0000, 1'b1);
    for (int i = 0; i < 15; i++) cycle(1'b0, 1'b0, 16'h0000, 1'b1);
    check("halted_sticky", 32'(halted), 32'd1);
    check("idle_after_halt", 32'(instr_valid), 32'd0);
    check("no_req_after_halt", 32'(imem_req), 32'd0);

    // Redirect near the top of the address space to exercise wrap.
    halt_en = 1'b0;
    cycle(1'b0, 1'b1, 16'hFFFC, 1'b1);
    check("halt_cleared", 32'(halted), 32'd0);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 16'h0000, 1'b1);

    // Reset in the middle of a stream.
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 16'h0000, 1'b1);
    cycle(1'b1, 1'b0, 16'h0000, 1'b1);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 16'h0000, 1'b1);

    // Randomized traffic.
    scramble = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      rdr = ($urandom_range(0, 29) == 0);
      rdy = ($urandom_range(0, 9) < 7);
      rpc = 16'($urandom);
      if (rst) begin
        halt_en   = ($urandom_range(0, 1) == 1);
        halt_addr = 16'(2 * $urandom_range(0, 10));
      end else if (rdr) begin
        halt_en   = ($urandom_range(0, 1) == 1);
        halt_addr = (rpc & 16'hFFFE) + 16'(2 * $urandom_range(0, 10));
      end
      cycle(rst, rdr, rpc, rdy);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
